// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: fetch packets and instruction-queue entries.
package rv32i_types;

  localparam int unsigned IQ_DEPTH = 16;
  localparam int unsigned GHR_W    = 8;

  typedef struct packed {
    logic [31:0]      i;
    logic             i_valid;
    logic [31:0]      i_pc;
    logic [31:0]      i_pc_next;
    logic             br_pred;
    logic [GHR_W-1:0] br_commit_ghr;
  } fetch_pkt_t;

  typedef struct packed {
    logic [31:0]      i;
    logic [63:0]      i_order;
    logic             i_valid;
    logic [31:0]      i_pc;
    logic [31:0]      i_pc_next;
    logic             br_pred;
    logic [GHR_W-1:0] br_commit_ghr;
  } inst_t;

  typedef struct packed {
    inst_t inst;
  } iq_entry;

  // Attach a commit order to a fetched packet.
  function automatic iq_entry stamp_entry(fetch_pkt_t pkt, logic [63:0] order);
    iq_entry e;
    e.inst.i             = pkt.i;
    e.inst.i_order       = order;
    e.inst.i_valid       = pkt.i_valid;
    e.inst.i_pc          = pkt.i_pc;
    e.inst.i_pc_next     = pkt.i_pc_next;
    e.inst.br_pred       = pkt.br_pred;
    e.inst.br_commit_ghr = pkt.br_commit_ghr;
    return e;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular fetch->decode instruction queue with commit-order stamping and one-cycle flush.
// Optional IQ_BYPASS_EN: empty-queue combinational pass-through from enq to iq_out.
module inst_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_valid,
  input  fetch_pkt_t               enq_pkt,
  output logic                     enq_ready,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output iq_entry                  iq_out,
  input  logic                     flush,
  input  logic [63:0]              flush_order,
  output logic [$clog2(DEPTH):0]   iq_count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [63:0]   order_q, order_d;
  iq_entry       mem_q [DEPTH];

  logic empty, full;
  logic wr_en;
  logic byp;
  logic byp_through;

  assign empty     = (head_q == tail_q);
  assign full      = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
  assign enq_ready = !full;
  assign iq_count  = tail_q - head_q;

`ifdef IQ_BYPASS_EN
  // Reset gating keeps deq_valid low while rst_n is held, even with enq_valid up.
  assign byp       = rst_n && empty && enq_valid && !flush;
  assign deq_valid = !empty || byp;
  assign iq_out    = byp ? stamp_entry(enq_pkt, order_q) : mem_q[head_q[IW-1:0]];
`else
  assign byp       = 1'b0;
  assign deq_valid = !empty;
  assign iq_out    = mem_q[head_q[IW-1:0]];
`endif

  // An empty-queue bypass that decode accepts never occupies a slot.
  assign byp_through = byp && deq_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    order_d = order_q;
    wr_en   = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      order_d = flush_order + 64'd1;
    end else begin
      if (enq_valid && enq_ready) begin
        order_d = order_q + 64'd1;
        if (!byp_through) begin
          wr_en  = 1'b1;
          tail_d = tail_q + 1'b1;
        end
      end
      if (deq_valid && deq_ready && !empty) begin
        head_d = head_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      order_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      order_q <= order_d;
    end
  end

  // Storage is intentionally not reset; entries are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q[IW-1:0]] <= stamp_entry(enq_pkt, order_q);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue with an expected-entry scoreboard.
module tb_inst_queue;
  import rv32i_types::*;

  localparam int unsigned DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   enq_valid;
  fetch_pkt_t             enq_pkt;
  logic                   enq_ready;
  logic                   deq_valid;
  logic                   deq_ready;
  iq_entry                iq_out;
  logic                   flush;
  logic [63:0]            flush_order;
  logic [$clog2(DEPTH):0] iq_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  iq_entry     sb[$];
  logic [63:0] exp_order;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_valid  (enq_valid),
    .enq_pkt    (enq_pkt),
    .enq_ready  (enq_ready),
    .deq_valid  (deq_valid),
    .deq_ready  (deq_ready),
    .iq_out     (iq_out),
    .flush      (flush),
    .flush_order(flush_order),
    .iq_count   (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pkt(input logic [31:0] pc);
    enq_pkt.i             = {pc[15:0], 16'h0013};
    enq_pkt.i_valid       = pc[2];
    enq_pkt.i_pc          = pc;
    enq_pkt.i_pc_next     = pc + 32'd4;
    enq_pkt.br_pred       = pc[3];
    enq_pkt.br_commit_ghr = pc[11:4];
  endtask

  function automatic iq_entry mk_exp(input fetch_pkt_t p, input logic [63:0] o);
    iq_entry e;
    e.inst.i             = p.i;
    e.inst.i_order       = o;
    e.inst.i_valid       = p.i_valid;
    e.inst.i_pc          = p.i_pc;
    e.inst.i_pc_next     = p.i_pc_next;
    e.inst.br_pred       = p.br_pred;
    e.inst.br_commit_ghr = p.br_commit_ghr;
    return e;
  endfunction

  // One clock: check outputs at the falling edge against the model, update the
  // scoreboard with what should fire at the next rising edge, then step past it.
  task automatic cycle();
    int   occ;
    logic exp_dv;
    logic exp_er;
    iq_entry e;
    @(negedge clk);
    occ    = sb.size();
    exp_er = (occ != DEPTH);
    exp_dv = (occ != 0);
`ifdef IQ_BYPASS_EN
    if (occ == 0 && enq_valid && !flush) exp_dv = 1'b1;
`endif
    check("iq_count", 64'(iq_count), 64'(occ));
    check("enq_ready", 64'(enq_ready), 64'(exp_er));
    check("deq_valid", 64'(deq_valid), 64'(exp_dv));
    if (flush) begin
      sb.delete();
      exp_order = flush_order + 64'd1;
    end else begin
      if (enq_valid && exp_er) begin
        sb.push_back(mk_exp(enq_pkt, exp_order));
        exp_order = exp_order + 64'd1;
      end
      if (exp_dv && deq_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("out_order", iq_out.inst.i_order, e.inst.i_order);
          check("out_pc", 64'(iq_out.inst.i_pc), 64'(e.inst.i_pc));
          check("out_i", 64'(iq_out.inst.i), 64'(e.inst.i));
          check("out_pc_next", 64'(iq_out.inst.i_pc_next), 64'(e.inst.i_pc_next));
          check("out_flags", 64'({iq_out.inst.i_valid, iq_out.inst.br_pred,
                                  iq_out.inst.br_commit_ghr}),
                64'({e.inst.i_valid, e.inst.br_pred, e.inst.br_commit_ghr}));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    enq_valid   = 1'b0;
    deq_ready   = 1'b0;
    flush       = 1'b0;
    flush_order = '0;
    exp_order   = '0;
    set_pkt(32'h0);
    #12;
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_iq_count", 64'(iq_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Three enqueues held, then drained in order.
    enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_pkt(32'h1000 + 32'(4 * k));
      cycle();
    end
    enq_valid = 1'b0;
    check("fill3_count", 64'(iq_count), 64'd3);
    deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    check("drain3_deq_valid", 64'(deq_valid), 64'd0);

    // Fill to DEPTH, hold enq_valid while full, free one slot.
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      set_pkt(32'h3000 + 32'(4 * k));
      cycle();
    end
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    check("full_count", 64'(iq_count), 64'(DEPTH));
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    cycle();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) cycle();
    check("full_drained", 64'(sb.size()), 64'd0);

    // Steady state: enqueue and dequeue every cycle across 20 entries.
    enq_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_pkt(32'h4000 + 32'(4 * k));
      cycle();
    end
    enq_valid = 1'b0;
    for (int k = 0; k < 2; k++) cycle();

    // Flush with concurrent enqueue/dequeue requests.
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_pkt(32'h5000 + 32'(4 * k));
      cycle();
    end
    flush       = 1'b1;
    flush_order = 64'd41;
    deq_ready   = 1'b1;
    set_pkt(32'h5100);
    cycle();
    flush     = 1'b0;
    enq_valid = 1'b0;
    #1;
    check("flush_deq_valid", 64'(deq_valid), 64'd0);
    check("flush_count", 64'(iq_count), 64'd0);
    check("flush_enq_ready", 64'(enq_ready), 64'd1);
    enq_valid = 1'b1;
    deq_ready = 1'b0;
    set_pkt(32'h5200);
    cycle();
    enq_valid = 1'b0;
    check("post_flush_order", iq_out.inst.i_order, 64'd42);
    deq_ready = 1'b1;
    cycle();

    // Asynchronous reset mid-burst with two entries queued.
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_pkt(32'h6000 + 32'(4 * k));
      cycle();
    end
    set_pkt(32'h6008);
    #3 rst_n = 1'b0;
    #1;
    check("arst_enq_ready", 64'(enq_ready), 64'd1);
    check("arst_deq_valid", 64'(deq_valid), 64'd0);
    check("arst_iq_count", 64'(iq_count), 64'd0);
    sb.delete();
    exp_order = '0;
    enq_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    enq_valid = 1'b1;
    set_pkt(32'h7000);
    cycle();
    enq_valid = 1'b0;
    check("post_rst_order", iq_out.inst.i_order, 64'd0);
    deq_ready = 1'b1;
    cycle();

    // Empty queue with enq and deq both active: bypass vs. one-cycle latency.
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    set_pkt(32'h2000);
    #1;
`ifdef IQ_BYPASS_EN
    check("byp_deq_valid", 64'(deq_valid), 64'd1);
    check("byp_pc", 64'(iq_out.inst.i_pc), 64'h2000);
    check("byp_count", 64'(iq_count), 64'd0);
`else
    check("nobyp_deq_valid", 64'(deq_valid), 64'd0);
`endif
    cycle();
    enq_valid = 1'b0;
    #1;
`ifdef IQ_BYPASS_EN
    check("byp_after_count", 64'(iq_count), 64'd0);
`else
    check("nobyp_late_valid", 64'(deq_valid), 64'd1);
    check("nobyp_late_pc", 64'(iq_out.inst.i_pc), 64'h2000);
`endif
    for (int k = 0; k < 2; k++) cycle();
    check("final_empty", 64'(deq_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Circular instruction queue between fetch and decode. Accepts fetched instruction packets from the fetch stage, stamps each with a monotonic commit order, and presents the oldest entry to decode as `iq_entry` with a valid/ready handshake. It absorbs fetch/decode rate mismatch and is emptied in one cycle on a branch-mispredict flush.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `clk  in  1`: clock, rising-edge.
- `rst_n  in  1`: asynchronous active-low reset.
- `enq_valid  in  1`: fetch presents a packet.
- `enq_pkt  in  fetch_pkt_t`: `i`, `i_valid`, `i_pc`, `i_pc_next`, `br_pred`, `br_commit_ghr`.
- `enq_ready  out  1`: queue can accept; equals `!full`, with no dependence on `deq_ready`.
- `deq_valid  out  1`: `iq_out` holds a valid entry.
- `deq_ready  in  1`: decode/dispatch accepts `iq_out` this cycle.
- `iq_out  out  iq_entry`: oldest entry; `inst.i_order` is filled in.
- `flush  in  1`: mispredict or redirect; discard all contents.
- `flush_order  in  64`: order of the redirecting instruction.
- `iq_count  out  $clog2(DEPTH)+1`: current occupancy, for perf counters.

## Operation
- Storage: `DEPTH` × `iq_entry` array; `head` and `tail` pointers of `$clog2(DEPTH)+1` bits.
  - Extra MSB is the wrap bit.
  - Empty when `head == tail`.
  - Full when the index bits are equal and the MSBs differ.
  - Index wraps from `DEPTH-1` to 0 with the MSB toggled.
- Enqueue fires on `enq_valid && enq_ready`:
  - Write `enq_pkt` at `tail`, with `i_order = order_ctr`.
  - `tail++`, `order_ctr++`.
- Dequeue fires on `deq_valid && deq_ready`: `head++`.
- Simultaneous enqueue and dequeue, non-empty and non-full: both fire; count unchanged.
- Full: `enq_ready = 0`, even if `deq_ready = 1` that cycle. The slot is reusable the following cycle.
- Empty: `deq_valid = 0`; `iq_out` is the stale entry at `head`, which decode ignores.
- `i_valid` passes through unmodified. Decode qualifies it further.
- `order_ctr` is 64 bits and wraps modulo 2^64.
- `flush` has the highest priority:
  - `head = tail = 0`; count 0.
  - Any enqueue or dequeue in that cycle is discarded.
  - `order_ctr <= flush_order + 1`.
- Reset (asynchronous, any cycle, mid-operation included):
  - `head = tail = 0`, `order_ctr = 0`.
  - `enq_ready = 1`, `deq_valid = 0`, `iq_count = 0`.
  - Array contents are not reset. `iq_out` is don't-care while `deq_valid = 0`.

## Timing
- Enqueue-to-visible latency is 1 cycle: an entry written at edge N is on `iq_out` with `deq_valid = 1` after edge N, when the queue was empty. Bypass reduces this (see Configuration).
- `enq_ready` and `iq_count` are functions of registered pointers only.
- `deq_valid` is registered-only without bypass.
- Throughput: one enqueue and one dequeue per cycle.
- After a flush at edge N, `enq_ready = 1` and `deq_valid = 0` in cycle N+1. A new enqueue in N+1 gets `i_order = flush_order + 1`.

## Configuration
- Macro: `IQ_BYPASS_EN`.
- Defined — when the queue is empty and `enq_valid = 1`:
  - `deq_valid = 1` combinationally and `iq_out` is `enq_pkt`, stamped with `order_ctr`.
  - If `deq_ready = 1`, the entry passes through: pointers unchanged, `order_ctr++`.
  - If `deq_ready = 0`, the entry is stored normally.
  - `flush` still suppresses both `deq_valid` and the write.
- Undefined: no combinational path from `enq_*` to `deq_valid`/`iq_out`; minimum latency 1 cycle.

## Structure
- `rv32i_types` holds:
  - `fetch_pkt_t`.
  - `iq_entry` (field `inst`, carrying `i`, `i_order`, `i_valid`, `i_pc`, `i_pc_next`, `br_pred`, `br_commit_ghr`).
  - `IQ_DEPTH` default constant.
- Single module. The pointer/full/empty logic is small enough that no sub-module is warranted.

## Test plan
- Reset, then enqueue PCs 0x1000, 0x1004, 0x1008 with `deq_ready = 0` → `iq_count = 3`. Then set `deq_ready = 1` → `iq_out.i_pc` is 0x1000, 0x1004, 0x1008 on successive cycles with `i_order` 0, 1, 2. `deq_valid` falls after the third.
- `DEPTH = 4`: enqueue 4 with `deq_ready = 0` → `enq_ready = 0`, `iq_count = 4`. Hold `enq_valid`; one dequeue → `enq_ready = 1` the next cycle. No packet is lost or duplicated.
- Steady state, enqueue and dequeue every cycle across 20 entries → pointer wrap is exercised; orders 0..19 come out in order; count stays constant.
- 3 entries queued; assert `flush` with `flush_order = 41`, while `enq_valid` and `deq_ready` are also 1 → next cycle `deq_valid = 0`, `iq_count = 0`. The next enqueue carries `i_order = 42`.
- Assert `rst_n` low mid-burst with 2 entries queued → outputs go to reset values asynchronously. After release, the first enqueue carries `i_order = 0`.
- With `IQ_BYPASS_EN`: empty queue, `enq_valid = deq_ready = 1`, `i_pc` 0x2000 → `iq_out.i_pc = 0x2000` with `deq_valid = 1` in the same cycle; `iq_count` stays 0. Without the macro → visible 1 cycle later.
